fp_normalize: RTL and testbench

- Post-add normalization and packing stage for the 8-bit mini-float datapath: 3-bit exponent, 4-bit fraction, hidden leading one.
- Takes the raw 8-bit mantissa sum produced after operand alignment and addition, plus the larger operand's exponent.
- Shifts the sum iteratively, one bit per cycle, until the leading one sits in the hidden-bit position, adjusting the exponent on each shift.
- Rounds and repacks the result into exponent/fraction form, with valid/ready handshakes on both sides.

---
 rtl/fp_normalize.sv | 167 ++++++++++++++++
 tb/tb_fp_normalize.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize.sv
// Post-add normalize/round/pack stage for the 8-bit mini-float (3-bit exp, 4-bit fraction).
// Optional round-to-nearest-even in ROUND when ROUND_NEAREST_EN is defined; truncation otherwise.
module fp_normalize (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] sum_mant,
    input  logic [2:0] exp_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] exp_out,
    output logic [3:0] fract_out,
    output logic       ovf,
    output logic       unf,
    output logic       zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] mant_q, mant_d;
    logic [2:0] exp_q, exp_d;
    logic       sticky_q, sticky_d;
    logic       out_valid_q, out_valid_d;
    logic [2:0] exp_out_q, exp_out_d;
    logic [3:0] fract_out_q, fract_out_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       zero_q, zero_d;

`ifdef ROUND_NEAREST_EN
    logic round_up;
    logic round_carry;

    // Carry out of bits 6:2 happens only when all five bits are already ones.
    always_comb begin
        round_up    = mant_q[1] & (mant_q[0] | sticky_q | mant_q[2]);
        round_carry = &mant_q[6:2];
    end
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        exp_out_d   = exp_out_q;
        fract_out_d = fract_out_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mant_d   = sum_mant;
                    exp_d    = exp_in;
                    sticky_d = 1'b0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = NORM;
                end
            end

            NORM: begin
                if (mant_q[7] && (exp_q == 3'd7)) begin
                    ovf_d   = 1'b1;
                    mant_d  = 8'h7F;
                    state_d = ROUND;
                end else if (mant_q[7]) begin
                    mant_d   = mant_q >> 1;
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_q + 3'd1;
                    state_d  = ROUND;
                end else if (mant_q == 8'd0) begin
                    zero_d  = 1'b1;
                    exp_d   = 3'd0;
                    state_d = ROUND;
                end else if (mant_q[6]) begin
                    state_d = ROUND;
                end else if (exp_q == 3'd0) begin
                    // Out of exponent range: leave the mantissa denormal.
                    unf_d   = 1'b1;
                    state_d = ROUND;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - 3'd1;
                end
            end

            ROUND: begin
                exp_out_d   = exp_q;
                fract_out_d = mant_q[5:2];
`ifdef ROUND_NEAREST_EN
                if (round_up) begin
                    if (!round_carry) begin
                        fract_out_d = mant_q[5:2] + 4'd1;
                    end else if (exp_q == 3'd7) begin
                        ovf_d       = 1'b1;
                        exp_out_d   = 3'd7;
                        fract_out_d = 4'hF;
                    end else begin
                        exp_out_d   = exp_q + 3'd1;
                        fract_out_d = 4'd0;
                    end
                end
`endif
                out_valid_d = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
        if (!rst_n) begin
            state_q     <= IDLE;
            mant_q      <= 8'd0;
            exp_q       <= 3'd0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            exp_out_q   <= 3'd0;
            fract_out_q <= 4'd0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            exp_out_q   <= exp_out_d;
            fract_out_q <= fract_out_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign exp_out   = exp_out_q;
    assign fract_out = fract_out_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Scoreboard bench for fp_normalize: directed cases, backpressure, reset abort and random vectors.
// Expected rounding follows ROUND_NEAREST_EN when the macro is defined for the build.
module tb_fp_normalize;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sum_mant;
    logic [2:0] exp_in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] exp_out;
    logic [3:0] fract_out;
    logic       ovf, unf, zero;

    fp_normalize dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_mant  (sum_mant),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .fract_out (fract_out),
        .ovf       (ovf),
        .unf       (unf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ex;
        logic [3:0] fr;
        logic       o;
        logic       u;
        logic       z;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   seen     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic exp_t mk(input logic [2:0] ex, input logic [3:0] fr,
                                input logic o, input logic u, input logic z, input int lat);
        exp_t x;
        x.ex = ex; x.fr = fr; x.o = o; x.u = u; x.z = z; x.lat = lat; x.acc = 0;
        return x;
    endfunction

    // Behavioural reference: normalize by rules, then optional nearest-even rounding.
    function automatic exp_t model(input logic [7:0] s, input logic [2:0] e);
        logic [7:0] m  = s;
        logic [2:0] x  = e;
        logic       st = 1'b0;
        exp_t       r  = mk(3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3);
        if (m[7]) begin
            if (x == 3'd7) begin
                r.o = 1'b1;
                m   = 8'h7F;
            end else begin
                st = m[0];
                m  = m >> 1;
                x  = x + 3'd1;
            end
        end else if (m == 8'd0) begin
            r.z = 1'b1;
            x   = 3'd0;
        end else begin
            while (!m[6] && x != 3'd0) begin
                m = m << 1;
                x = x - 3'd1;
                r.lat++;
            end
            if (!m[6]) r.u = 1'b1;
        end
        r.ex = x;
        r.fr = m[5:2];
`ifdef ROUND_NEAREST_EN
        if (m[1] && (m[0] || st || m[2])) begin
            logic [5:0] sum6;
            sum6 = {1'b0, m[6:2]} + 6'd1;
            if (sum6[5]) begin
                if (x == 3'd7) begin
                    r.o = 1'b1; r.ex = 3'd7; r.fr = 4'hF;
                end else begin
                    r.ex = x + 3'd1; r.fr = 4'd0;
                end
            end else begin
                r.fr = sum6[3:0];
            end
        end
`else
        if (st) r.lat = r.lat;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compare the head of the scoreboard when a result appears, pop on handshake.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("latency",   cyc - sb[0].acc + 1, sb[0].lat);
                    check("exp_out",   exp_out,   sb[0].ex);
                    check("fract_out", fract_out, sb[0].fr);
                    check("ovf",       ovf,       sb[0].o);
                    check("unf",       unf,       sb[0].u);
                    check("zero",      zero,      sb[0].z);
                end
            end
            if (out_ready) begin
                if (sb.size() != 0) void'(sb.pop_front());
                seen = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] s, input logic [2:0] e, input exp_t x);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_send", in_ready, 1);
        sum_mant = s;
        exp_in   = e;
        in_valid = 1'b1;
        tick();
        x.acc = cyc;
        sb.push_back(x);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 40) begin
            tick();
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic run_case(input logic [7:0] s, input logic [2:0] e, input exp_t x);
        send(s, e, x);
        drain();
    endtask

    initial begin
        logic [2:0] hold_ex;
        logic [3:0] hold_fr;
        int         n;
        logic [7:0] rs;
        logic [2:0] re;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum_mant  = 8'd0;
        exp_in    = 3'd0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_exp_out",   exp_out,   0);
        check("rst_fract_out", fract_out, 0);
        check("rst_flags",     {ovf, unf, zero}, 0);
        rst_n = 1'b1;
        tick();

        run_case(8'b0100_1100, 3'd3, mk(3'd3, 4'b0011, 0, 0, 0, 3));
        run_case(8'b1011_0000, 3'd2, mk(3'd3, 4'b0110, 0, 0, 0, 3));

        // Left shift by three with in_valid pulses that must be ignored while busy.
        send(8'b0000_1010, 3'd5, mk(3'd2, 4'b0100, 0, 0, 0, 6));
        for (int i = 0; i < 3; i++) begin
            check("busy_in_ready", in_ready, 0);
            sum_mant = 8'hFF;
            exp_in   = 3'd7;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        drain();

        run_case(8'h00,        3'd4, mk(3'd0, 4'h0,    0, 0, 1, 3));
        run_case(8'b1000_0000, 3'd7, mk(3'd7, 4'hF,    1, 0, 0, 3));
        run_case(8'b0000_0100, 3'd2, mk(3'd0, 4'b0100, 0, 1, 0, 5));

`ifdef ROUND_NEAREST_EN
        run_case(8'b0100_0110, 3'd1, mk(3'd1, 4'b0010, 0, 0, 0, 3));
        run_case(8'b0111_1110, 3'd7, mk(3'd7, 4'hF,    1, 0, 0, 3));
`else
        run_case(8'b0100_0110, 3'd1, mk(3'd1, 4'b0001, 0, 0, 0, 3));
        run_case(8'b0111_1110, 3'd7, mk(3'd7, 4'hF,    0, 0, 0, 3));
`endif

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(8'b1011_0000, 3'd2, mk(3'd3, 4'b0110, 0, 0, 0, 3));
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_out_valid", out_valid, 1);
        hold_ex = exp_out;
        hold_fr = fract_out;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_exp",   exp_out,   hold_ex);
            check("bp_hold_fract", fract_out, hold_fr);
            check("bp_in_ready",   in_ready,  0);
        end
        out_ready = 1'b1;
        tick();
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready",  in_ready,  1);
        drain();

        // Reset while shifting aborts the transaction with no output.
        send(8'h01, 3'd7, mk(3'd1, 4'h0, 0, 0, 0, 9));
        tick();
        check("pre_rst_busy", in_ready, 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready",  in_ready,  1);
        sb.delete();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) n++;
        end
        check("no_output_after_abort", n, 0);

        for (int i = 0; i < 24; i++) begin
            rs = 8'($urandom_range(0, 255));
            re = 3'($urandom_range(0, 7));
            run_case(rs, re, model(rs, re));
        end
        run_case(8'h01, 3'd7, model(8'h01, 3'd7));
        run_case(8'hFF, 3'd3, model(8'hFF, 3'd3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
